ibufds_gte3_refclk_rx: RTL

Receive-side counterpart of the GT reference-clock output buffer. It samples a differential refclk pair (I/IB) in the CLK domain and resolves it to a single-ended level with legality checking. It gates the result with a CEB power-up lockout, produces O and a selectable ODIV2 output, and reports clock activity. It sits between the package refclk pins and the GT/HROW clock-distribution models in the simulation library.

---
 rtl/ibufds_gte3_refclk_rx_pkg.sv | 25 ++
 rtl/ibufds_gte3_refclk_rx_if.sv | 25 ++
 rtl/ibufds_gte3_refclk_rx_activity_mon.sv | 53 +++++
 rtl/ibufds_gte3_refclk_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ibufds_gte3_refclk_rx_pkg.sv
// Shared definitions for the GT refclk receive buffer model: ODIV2 source
// encodings, enable-FSM state codes and legal differential-pair decodes.
package ibufds_gte3_refclk_rx_pkg;

  // ODIV2 source select encodings (2'b11 behaves like SEL_ZERO)
  localparam logic [1:0] SEL_O    = 2'b00;
  localparam logic [1:0] SEL_DIV2 = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

  // Enable FSM state codes
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_OFF     = 2'd0;
  localparam fsm_state_t ST_LOCKOUT = 2'd1;
  localparam fsm_state_t ST_RUN     = 2'd2;

  // Legal differential pairs, packed as {I, IB}
  localparam logic [1:0] PAIR_HIGH = 2'b10;
  localparam logic [1:0] PAIR_LOW  = 2'b01;

  // A pair is legal only when the two legs disagree
  function automatic logic pair_legal(input logic [1:0] pair);
    return pair[1] ^ pair[0];
  endfunction

endpackage

// File: rtl/ibufds_gte3_refclk_rx_if.sv
// Pin-side bundle of the refclk receive buffer: power-down control, the
// differential pair and the resolved clock / status outputs.
interface ibufds_gte3_refclk_rx_if;

  logic CEB;
  logic I;
  logic IB;
  logic O;
  logic ODIV2;
  logic VALID;
  logic ACTIVE;

  // Source side: drives the pair and CEB, observes the buffer outputs
  modport master (
    output CEB, I, IB,
    input  O, ODIV2, VALID, ACTIVE
  );

  // Buffer side
  modport slave (
    input  CEB, I, IB,
    output O, ODIV2, VALID, ACTIVE
  );

endinterface

// File: rtl/ibufds_gte3_refclk_rx_activity_mon.sv
// Refclk activity monitor: counts rising edges of the resolved clock over a
// fixed window and flags the window as active when enough edges were seen.
// Everything is held cleared while run_en is low, so a partial window is
// discarded whenever the buffer leaves its running state.
module ibufds_gte3_refclk_rx_activity_mon
  import ibufds_gte3_refclk_rx_pkg::*;
#(
  parameter int ACT_WINDOW    = 64,
  parameter int ACT_MIN_EDGES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic run_en,
  input  logic rise,
  output logic active
);

  localparam int WIN_W = $clog2(ACT_WINDOW + 1);
  localparam int EDG_W = $clog2(ACT_MIN_EDGES + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ACT_WINDOW - 1);
  localparam logic [EDG_W-1:0] EDGE_MAX = EDG_W'(ACT_MIN_EDGES);

  logic [WIN_W-1:0] win_cnt_p0;
  logic [EDG_W-1:0] edge_cnt_p0;

  // Edge count plus an optional increment, pinned at the threshold so the
  // counter can never wrap no matter how fast the refclk is
  function automatic logic [EDG_W-1:0] sat_inc(input logic [EDG_W-1:0] cnt,
                                               input logic             inc);
    if (inc && (cnt != EDGE_MAX)) begin
      return cnt + EDG_W'(1);
    end
    return cnt;
  endfunction

  // Window/edge counting; the wrap cycle's own rise belongs to the ending window
  always_ff @(posedge CLK) begin
    if (RST || !run_en) begin
      win_cnt_p0  <= '0;
      edge_cnt_p0 <= '0;
      active      <= 1'b0;
    end else if (win_cnt_p0 == WIN_LAST) begin
      active      <= (sat_inc(edge_cnt_p0, rise) >= EDGE_MAX);
      win_cnt_p0  <= '0;
      edge_cnt_p0 <= '0;
    end else begin
      win_cnt_p0  <= win_cnt_p0 + WIN_W'(1);
      edge_cnt_p0 <= sat_inc(edge_cnt_p0, rise);
    end
  end

endmodule

// File: rtl/ibufds_gte3_refclk_rx.sv
// GT reference-clock receive buffer model. The asynchronous differential
// pair is synchronised into CLK, resolved to a single-ended level (illegal
// 00/11 pairs hold the last level and drop VALID), gated by a CEB power-up
// lockout, and presented as O plus a selectable ODIV2 with activity status.
module ibufds_gte3_refclk_rx
  import ibufds_gte3_refclk_rx_pkg::*;
#(
  parameter logic       REFCLK_EN_RX_PATH  = 1'b1,
  parameter logic [1:0] REFCLK_HROW_CK_SEL = 2'b00,
  parameter int         CEB_LOCKOUT_CYCLES = 16,
  parameter int         ACT_WINDOW         = 64,
  parameter int         ACT_MIN_EDGES      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  ibufds_gte3_refclk_rx_if.slave bus
);

  localparam int LCK_W = $clog2(CEB_LOCKOUT_CYCLES + 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(CEB_LOCKOUT_CYCLES - 1);

  // Input pipeline: {I, IB} pairs
  logic [1:0] pair_meta_p0;
  logic [1:0] pair_sync_p1;
  logic       d_p2;
  logic       d_prev_p2;
  logic       vld_p2;

  // Enable FSM
  fsm_state_t       state;
  logic [LCK_W-1:0] lock_cnt;
  logic             run_en;

  // Output stage
  logic rise;
  logic div_p3;
  logic o_p3;
  logic odiv2_p3;
  logic active;

  // Resolved level for a synchronised pair: legal pairs take I, illegal
  // pairs keep whatever level was last resolved
  function automatic logic resolve_pair(input logic [1:0] pair,
                                        input logic       held);
    if (pair == PAIR_HIGH) begin
      return 1'b1;
    end
    if (pair == PAIR_LOW) begin
      return 1'b0;
    end
    return held;
  endfunction

  // ---- stage p0/p1: two-flop synchroniser on each leg ----
  // Double-register both legs; they are asynchronous to CLK
  always_ff @(posedge CLK) begin
    if (RST) begin
      pair_meta_p0 <= '0;
      pair_sync_p1 <= '0;
    end else begin
      pair_meta_p0 <= {bus.I, bus.IB};
      pair_sync_p1 <= pair_meta_p0;
    end
  end

  // ---- stage p2: pair resolution ----
  // Resolve the pair and keep the previous level for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      d_p2      <= 1'b0;
      d_prev_p2 <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      d_p2      <= resolve_pair(pair_sync_p1, d_p2);
      d_prev_p2 <= d_p2;
      vld_p2    <= pair_legal(pair_sync_p1);
    end
  end

  // Power-up sequencing: OFF until CEB low, then a lockout count before RUN
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_OFF;
      lock_cnt <= '0;
    end else if (bus.CEB || !REFCLK_EN_RX_PATH) begin
      state    <= ST_OFF;
      lock_cnt <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          state    <= ST_LOCKOUT;
          lock_cnt <= '0;
        end
        ST_LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            state    <= ST_RUN;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + LCK_W'(1);
          end
        end
        ST_RUN: begin
          state    <= ST_RUN;
          lock_cnt <= '0;
        end
        default: begin
          state    <= ST_OFF;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  // CEB is qualified here as well so a power-down blanks the outputs on the
  // very next edge rather than one cycle after the FSM falls back to OFF
  assign run_en = (state == ST_RUN) && !bus.CEB;
  assign rise   = d_p2 & ~d_prev_p2;

  // ---- stage p3: gated outputs ----
  // Drive O/ODIV2 from the resolved level while running, clear otherwise
  always_ff @(posedge CLK) begin
    if (RST || !run_en) begin
      o_p3     <= 1'b0;
      odiv2_p3 <= 1'b0;
      div_p3   <= 1'b0;
    end else begin
      o_p3   <= d_p2;
      div_p3 <= div_p3 ^ rise;
      case (REFCLK_HROW_CK_SEL)
        SEL_O:    odiv2_p3 <= d_p2;
        SEL_DIV2: odiv2_p3 <= div_p3;
        default:  odiv2_p3 <= 1'b0;
      endcase
    end
  end

  ibufds_gte3_refclk_rx_activity_mon #(
    .ACT_WINDOW    (ACT_WINDOW),
    .ACT_MIN_EDGES (ACT_MIN_EDGES)
  ) u_activity_mon (
    .CLK    (CLK),
    .RST    (RST),
    .run_en (run_en),
    .rise   (rise),
    .active (active)
  );

  assign bus.O      = o_p3;
  assign bus.ODIV2  = odiv2_p3;
  assign bus.VALID  = vld_p2;
  assign bus.ACTIVE = active;

endmodule
